// File: rtl/core_chk_pkg.sv
// Shared types for the writeback trace checker: FSM states, error codes and
// the expected-trace entry layout.
package core_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } chk_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_EXTRA_WB = 2'b11;

    // Entries are held at the widest supported datapath; narrower XLEN
    // values are zero-extended so equality still means exact field match.
    localparam int TRACE_XLEN_MAX = 64;

    typedef struct packed {
        logic [TRACE_XLEN_MAX-1:0] pc;
        logic [4:0]                rd;
        logic [TRACE_XLEN_MAX-1:0] val;
    } trace_entry_t;

    function automatic logic entry_match(input trace_entry_t a, input trace_entry_t b);
        return a == b;
    endfunction

endpackage

// File: rtl/chk_trace_ram.sv
// Expected-trace storage: one write port, asynchronous read so the entry at
// rd_ptr is available in the same cycle as the writeback it is checked against.
module chk_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_wb_checker.sv
// Compares a core's writeback stream against a preloaded expected trace and
// raises a sticky PASS/FAIL verdict. Define CHK_EXTRA_WB_EN to flag writebacks
// arriving after PASS as a failure.
module core_wb_checker
    import core_chk_pkg::*;
#(
    parameter int  XLEN    = 32,
    parameter int  DEPTH   = 64,
    parameter int  TIMEOUT = 4500,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EXEC,
    input  logic            EXP_WE,
    input  logic [XLEN-1:0] EXP_PC,
    input  logic [4:0]      EXP_RD,
    input  logic [XLEN-1:0] EXP_VAL,
    input  logic            M_VALID,
    input  logic [XLEN-1:0] M_PC,
    input  logic [4:0]      M_REG_D,
    input  logic [XLEN-1:0] M_REG_D_V,
    input  logic            STALL,
    output logic            DONE,
    output logic            PASS,
    output logic            FAIL,
    output logic [1:0]      ERR_CODE,
    output logic [AW-1:0]   ERR_IDX,
    output logic [AW:0]     MATCH_CNT,
    output logic [31:0]     CYC_CNT
);

    localparam int          ENTRY_W      = 2 * XLEN + 5;
    localparam logic [AW:0] DEPTH_CNT    = (AW+1)'(DEPTH);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    chk_state_t    state_reg, state_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW:0]   match_cnt_reg, match_cnt_next;
    logic [31:0]   cyc_cnt_reg, cyc_cnt_next;
    logic [1:0]    err_code_reg, err_code_next;
    logic [AW-1:0] err_idx_reg, err_idx_next;

    logic               ram_we;
    logic [ENTRY_W-1:0] ram_rdata;
    logic [AW:0]        count_m1;
    trace_entry_t       exp_entry;
    trace_entry_t       wb_entry;
    logic               qualify;
    logic               wb_match;
    logic               last_match;

    assign ram_we = (state_reg == ST_IDLE) && EXP_WE && (count_reg < DEPTH_CNT);

    chk_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_ram (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (count_reg[AW-1:0]),
        .wdata ({EXP_PC, EXP_RD, EXP_VAL}),
        .raddr (match_cnt_reg[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        exp_entry     = '0;
        exp_entry.pc  = TRACE_XLEN_MAX'(ram_rdata[ENTRY_W-1 -: XLEN]);
        exp_entry.rd  = ram_rdata[XLEN +: 5];
        exp_entry.val = TRACE_XLEN_MAX'(ram_rdata[XLEN-1:0]);
        wb_entry      = '0;
        wb_entry.pc   = TRACE_XLEN_MAX'(M_PC);
        wb_entry.rd   = M_REG_D;
        wb_entry.val  = TRACE_XLEN_MAX'(M_REG_D_V);
    end

    assign qualify    = M_VALID && !STALL && (M_REG_D != 5'd0);
    assign wb_match   = entry_match(wb_entry, exp_entry);
    assign count_m1   = count_reg - 1'b1;
    assign last_match = qualify && wb_match && ((match_cnt_reg + 1'b1) == count_reg);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        match_cnt_next = match_cnt_reg;
        cyc_cnt_next   = cyc_cnt_reg;
        err_code_next  = err_code_reg;
        err_idx_next   = err_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ram_we) begin
                    count_next = count_reg + 1'b1;
                end
                if (EXEC) begin
                    state_next     = ST_RUN;
                    match_cnt_next = '0;
                    cyc_cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (cyc_cnt_reg != '1) begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
                // Once every entry is matched, that cycle's writeback is not checked.
                if (match_cnt_reg == count_reg) begin
                    state_next = ST_PASS;
                end else if (qualify && !wb_match) begin
                    state_next    = ST_FAIL;
                    err_code_next = ERR_MISMATCH;
                    err_idx_next  = match_cnt_reg[AW-1:0];
                end else begin
                    if (qualify) begin
                        match_cnt_next = match_cnt_reg + 1'b1;
                    end
                    if ((cyc_cnt_reg == TIMEOUT_LAST) && !last_match) begin
                        state_next    = ST_FAIL;
                        err_code_next = ERR_TIMEOUT;
                        err_idx_next  = match_cnt_reg[AW-1:0];
                    end
                end
            end
            ST_PASS: begin
`ifdef CHK_EXTRA_WB_EN
                if (qualify) begin
                    state_next    = ST_FAIL;
                    err_code_next = ERR_EXTRA_WB;
                    err_idx_next  = count_m1[AW-1:0];
                end
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            match_cnt_reg <= '0;
            cyc_cnt_reg   <= '0;
            err_code_reg  <= ERR_NONE;
            err_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            match_cnt_reg <= match_cnt_next;
            cyc_cnt_reg   <= cyc_cnt_next;
            err_code_reg  <= err_code_next;
            err_idx_reg   <= err_idx_next;
        end
    end

    assign PASS      = (state_reg == ST_PASS);
    assign FAIL      = (state_reg == ST_FAIL);
    assign DONE      = PASS || FAIL;
    assign ERR_CODE  = err_code_reg;
    assign ERR_IDX   = err_idx_reg;
    assign MATCH_CNT = match_cnt_reg;
    assign CYC_CNT   = cyc_cnt_reg;

endmodule

// File: tb/tb_core_wb_checker.sv
// Scoreboard bench for core_wb_checker: expected verdicts are queued as each
// scenario is driven and compared when the checker reports DONE.
module tb_core_wb_checker;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;
    localparam int AW      = 3;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            EXEC = 1'b0;
    logic            EXP_WE = 1'b0;
    logic [XLEN-1:0] EXP_PC = '0;
    logic [4:0]      EXP_RD = '0;
    logic [XLEN-1:0] EXP_VAL = '0;
    logic            M_VALID = 1'b0;
    logic [XLEN-1:0] M_PC = '0;
    logic [4:0]      M_REG_D = '0;
    logic [XLEN-1:0] M_REG_D_V = '0;
    logic            STALL = 1'b0;
    logic            DONE, PASS, FAIL;
    logic [1:0]      ERR_CODE;
    logic [AW-1:0]   ERR_IDX;
    logic [AW:0]     MATCH_CNT;
    logic [31:0]     CYC_CNT;

    typedef struct {
        logic          pass;
        logic          fail;
        logic [1:0]    code;
        logic [AW-1:0] idx;
        logic [AW:0]   mcnt;
    } verdict_t;

    verdict_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tr_pc  [5] = '{32'h0, 32'hC, 32'h18, 32'h24, 32'h30};
    logic [31:0] tr_val [5] = '{32'd1000, 32'd3000, 32'd2000, 32'd0, 32'd1000};

    core_wb_checker #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EXEC      (EXEC),
        .EXP_WE    (EXP_WE),
        .EXP_PC    (EXP_PC),
        .EXP_RD    (EXP_RD),
        .EXP_VAL   (EXP_VAL),
        .M_VALID   (M_VALID),
        .M_PC      (M_PC),
        .M_REG_D   (M_REG_D),
        .M_REG_D_V (M_REG_D_V),
        .STALL     (STALL),
        .DONE      (DONE),
        .PASS      (PASS),
        .FAIL      (FAIL),
        .ERR_CODE  (ERR_CODE),
        .ERR_IDX   (ERR_IDX),
        .MATCH_CNT (MATCH_CNT),
        .CYC_CNT   (CYC_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; EXEC = 1'b0; EXP_WE = 1'b0; M_VALID = 1'b0; STALL = 1'b0;
        tick();
        RST = 1'b1;
    endtask

    task automatic load_entry(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
        EXP_WE = 1'b1; EXP_PC = pc; EXP_RD = rd; EXP_VAL = val;
        tick();
        EXP_WE = 1'b0;
    endtask

    task automatic load_trace5();
        for (int i = 0; i < 5; i++) load_entry(tr_pc[i], 5'(i + 1), tr_val[i]);
    endtask

    task automatic drive_wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
        $display("[TB] wb pc=%h rd=%0d val=%h", pc, rd, val);
        M_VALID = 1'b1; M_PC = pc; M_REG_D = rd; M_REG_D_V = val;
        tick();
        M_VALID = 1'b0;
    endtask

    task automatic drive_nop();
        M_VALID = 1'b1; M_PC = 32'hDEAD; M_REG_D = 5'd0; M_REG_D_V = 32'd5;
        tick();
        M_VALID = 1'b0;
    endtask

    task automatic start_run();
        EXEC = 1'b1;
        tick();
        EXEC = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!DONE && k < budget) begin
            tick();
            k++;
        end
        if (DONE !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done: got DONE=%b want 1 within %0d cycles", DONE, budget);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE, ERR_IDX, MATCH_CNT, CYC_CNT} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got done=%b pass=%b fail=%b code=%b idx=%0d mcnt=%0d cyc=%0d want all 0",
                     DONE, PASS, FAIL, ERR_CODE, ERR_IDX, MATCH_CNT, CYC_CNT);
        end
        $display("[TB] reset state checked");
        RST = 1'b1;
    endtask

    task automatic test_pass();
        verdict_t e;
        do_reset();
        load_trace5();
        exp_q.push_back('{1'b1, 1'b0, 2'b00, 3'd0, 4'd5});
        start_run();
        for (int i = 0; i < 5; i++) begin
            drive_wb(tr_pc[i], 5'(i + 1), tr_val[i]);
            drive_nop();
        end
        wait_done(5);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE} !== {1'b1, e.pass, e.fail, e.code}) begin
            n_fail++;
            $display("FAIL pass_flags: got done/pass/fail/code=%b/%b/%b/%b want 1/%b/%b/%b",
                     DONE, PASS, FAIL, ERR_CODE, e.pass, e.fail, e.code);
        end
        n_tests++;
        if ({ERR_IDX, MATCH_CNT} !== {e.idx, e.mcnt}) begin
            n_fail++;
            $display("FAIL pass_counts: got idx=%0d mcnt=%0d want idx=%0d mcnt=%0d", ERR_IDX, MATCH_CNT, e.idx, e.mcnt);
        end
        n_tests++;
        if (CYC_CNT !== 32'd10) begin
            n_fail++;
            $display("FAIL pass_cyc: got %0d want 10", CYC_CNT);
        end
        $display("[TB] pass verdict pass=%b mcnt=%0d cyc=%0d", PASS, MATCH_CNT, CYC_CNT);
    endtask

    task automatic test_mismatch();
        verdict_t e;
        do_reset();
        load_trace5();
        exp_q.push_back('{1'b0, 1'b1, 2'b01, 3'd2, 4'd2});
        start_run();
        drive_wb(tr_pc[0], 5'd1, tr_val[0]);
        drive_wb(tr_pc[1], 5'd2, tr_val[1]);
        n_tests++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_early: got DONE=%b want 0", DONE);
        end
        drive_wb(tr_pc[2], 5'd3, 32'h7D1);
        wait_done(0);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE} !== {1'b1, e.pass, e.fail, e.code}) begin
            n_fail++;
            $display("FAIL mismatch_flags: got done/pass/fail/code=%b/%b/%b/%b want 1/%b/%b/%b",
                     DONE, PASS, FAIL, ERR_CODE, e.pass, e.fail, e.code);
        end
        n_tests++;
        if ({ERR_IDX, MATCH_CNT} !== {e.idx, e.mcnt}) begin
            n_fail++;
            $display("FAIL mismatch_counts: got idx=%0d mcnt=%0d want idx=%0d mcnt=%0d", ERR_IDX, MATCH_CNT, e.idx, e.mcnt);
        end
        $display("[TB] mismatch verdict code=%b idx=%0d mcnt=%0d", ERR_CODE, ERR_IDX, MATCH_CNT);
    endtask

    task automatic test_timeout();
        verdict_t e;
        do_reset();
        for (int i = 0; i < 3; i++) load_entry(tr_pc[i], 5'(i + 1), tr_val[i]);
        exp_q.push_back('{1'b0, 1'b1, 2'b10, 3'd1, 4'd1});
        start_run();
        drive_wb(tr_pc[0], 5'd1, tr_val[0]);
        repeat (98) tick();
        n_tests++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got DONE=%b after 99 run cycles want 0", DONE);
        end
        tick();
        wait_done(60);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE} !== {1'b1, e.pass, e.fail, e.code}) begin
            n_fail++;
            $display("FAIL timeout_flags: got done/pass/fail/code=%b/%b/%b/%b want 1/%b/%b/%b",
                     DONE, PASS, FAIL, ERR_CODE, e.pass, e.fail, e.code);
        end
        n_tests++;
        if ({ERR_IDX, MATCH_CNT, CYC_CNT} !== {e.idx, e.mcnt, 32'd100}) begin
            n_fail++;
            $display("FAIL timeout_counts: got idx=%0d mcnt=%0d cyc=%0d want idx=%0d mcnt=%0d cyc=100",
                     ERR_IDX, MATCH_CNT, CYC_CNT, e.idx, e.mcnt);
        end
        $display("[TB] timeout verdict code=%b idx=%0d cyc=%0d", ERR_CODE, ERR_IDX, CYC_CNT);
    endtask

    task automatic test_stall();
        verdict_t e;
        do_reset();
        load_entry(tr_pc[0], 5'd1, tr_val[0]);
        load_entry(tr_pc[1], 5'd2, tr_val[1]);
        exp_q.push_back('{1'b1, 1'b0, 2'b00, 3'd0, 4'd2});
        start_run();
        $display("[TB] wb pc=%h rd=1 held under stall", tr_pc[0]);
        M_VALID = 1'b1; M_PC = tr_pc[0]; M_REG_D = 5'd1; M_REG_D_V = tr_val[0]; STALL = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (MATCH_CNT !== 4'd0) begin
            n_fail++;
            $display("FAIL stall_hold: got mcnt=%0d want 0", MATCH_CNT);
        end
        STALL = 1'b0;
        tick();
        M_VALID = 1'b0;
        n_tests++;
        if (MATCH_CNT !== 4'd1) begin
            n_fail++;
            $display("FAIL stall_release: got mcnt=%0d want 1", MATCH_CNT);
        end
        // A load attempt during RUN must not grow the trace.
        EXP_WE = 1'b1; EXP_PC = 32'h40; EXP_RD = 5'd9; EXP_VAL = 32'd9;
        tick();
        EXP_WE = 1'b0;
        tick();
        n_tests++;
        if ({MATCH_CNT, DONE} !== {4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_once: got mcnt=%0d done=%b want mcnt=1 done=0", MATCH_CNT, DONE);
        end
        drive_wb(tr_pc[1], 5'd2, tr_val[1]);
        wait_done(3);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE, MATCH_CNT} !== {1'b1, e.pass, e.fail, e.code, e.mcnt}) begin
            n_fail++;
            $display("FAIL stall_verdict: got pass=%b fail=%b code=%b mcnt=%0d want pass=%b fail=%b code=%b mcnt=%0d",
                     PASS, FAIL, ERR_CODE, MATCH_CNT, e.pass, e.fail, e.code, e.mcnt);
        end
        $display("[TB] stall verdict pass=%b mcnt=%0d", PASS, MATCH_CNT);
    endtask

    task automatic test_extra_wb();
        verdict_t e;
        do_reset();
        load_entry(tr_pc[0], 5'd1, tr_val[0]);
        exp_q.push_back('{1'b1, 1'b0, 2'b00, 3'd0, 4'd1});
        start_run();
        drive_wb(tr_pc[0], 5'd1, tr_val[0]);
        wait_done(3);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE, MATCH_CNT} !== {1'b1, e.pass, e.fail, e.code, e.mcnt}) begin
            n_fail++;
            $display("FAIL extra_pre: got pass=%b fail=%b code=%b mcnt=%0d want pass=%b fail=%b code=%b mcnt=%0d",
                     PASS, FAIL, ERR_CODE, MATCH_CNT, e.pass, e.fail, e.code, e.mcnt);
        end
`ifdef CHK_EXTRA_WB_EN
        exp_q.push_back('{1'b0, 1'b1, 2'b11, 3'd0, 4'd1});
`else
        exp_q.push_back('{1'b1, 1'b0, 2'b00, 3'd0, 4'd1});
`endif
        drive_wb(32'h3C, 5'd6, 32'd7);
        tick();
        wait_done(1);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE} !== {1'b1, e.pass, e.fail, e.code}) begin
            n_fail++;
            $display("FAIL extra_post: got pass=%b fail=%b code=%b want pass=%b fail=%b code=%b",
                     PASS, FAIL, ERR_CODE, e.pass, e.fail, e.code);
        end
        n_tests++;
        if (ERR_IDX !== e.idx) begin
            n_fail++;
            $display("FAIL extra_idx: got %0d want %0d", ERR_IDX, e.idx);
        end
        $display("[TB] extra wb verdict pass=%b code=%b", PASS, ERR_CODE);
    endtask

    task automatic test_reset_mid_run();
        verdict_t e;
        do_reset();
        load_trace5();
        start_run();
        drive_wb(tr_pc[0], 5'd1, tr_val[0]);
        drive_wb(tr_pc[1], 5'd2, tr_val[1]);
        n_tests++;
        if (MATCH_CNT !== 4'd2) begin
            n_fail++;
            $display("FAIL midrun_matches: got mcnt=%0d want 2", MATCH_CNT);
        end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE, ERR_IDX, MATCH_CNT, CYC_CNT} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got done=%b pass=%b fail=%b code=%b idx=%0d mcnt=%0d cyc=%0d want all 0",
                     DONE, PASS, FAIL, ERR_CODE, ERR_IDX, MATCH_CNT, CYC_CNT);
        end
        exp_q.push_back('{1'b1, 1'b0, 2'b00, 3'd0, 4'd0});
        start_run();
        n_tests++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_latency: got DONE=%b on RUN entry want 0", DONE);
        end
        tick();
        wait_done(0);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE, MATCH_CNT} !== {1'b1, e.pass, e.fail, e.code, e.mcnt}) begin
            n_fail++;
            $display("FAIL empty_verdict: got pass=%b fail=%b code=%b mcnt=%0d want pass=%b fail=%b code=%b mcnt=%0d",
                     PASS, FAIL, ERR_CODE, MATCH_CNT, e.pass, e.fail, e.code, e.mcnt);
        end
        $display("[TB] reset mid-run then empty trace pass=%b", PASS);
    endtask

    task automatic test_overflow();
        verdict_t e;
        do_reset();
        for (int i = 0; i < 10; i++) load_entry(32'(i * 4), 5'(i + 1), 32'(i * 111));
        exp_q.push_back('{1'b1, 1'b0, 2'b00, 3'd0, 4'd8});
        start_run();
        for (int i = 0; i < 8; i++) drive_wb(32'(i * 4), 5'(i + 1), 32'(i * 111));
        wait_done(3);
        e = exp_q.pop_front();
        n_tests++;
        if ({DONE, PASS, FAIL, ERR_CODE, MATCH_CNT} !== {1'b1, e.pass, e.fail, e.code, e.mcnt}) begin
            n_fail++;
            $display("FAIL overflow_verdict: got pass=%b fail=%b code=%b mcnt=%0d want pass=%b fail=%b code=%b mcnt=%0d",
                     PASS, FAIL, ERR_CODE, MATCH_CNT, e.pass, e.fail, e.code, e.mcnt);
        end
        $display("[TB] overflow verdict pass=%b mcnt=%0d", PASS, MATCH_CNT);
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_stall();
        test_extra_wb();
        test_reset_mid_run();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
